// File: rtl/regfile_wb_if.sv
// regfile_wb_if: writeback write port plus two decode read ports of the integer register file.
// Signals:
//   we, waddr, wdata   - writeback write request (wb_wreg / wb_wd / wb_wdata)
//   re1, raddr1, rdata1 - read port 1 (enable, index, data)
//   re2, raddr2, rdata2 - read port 2 (enable, index, data)
// Modports: master = pipeline side (drives requests), slave = register file.
interface regfile_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    modport master (output we, waddr, wdata, re1, raddr1, re2, raddr2, input rdata1, rdata2);
    modport slave  (input we, waddr, wdata, re1, raddr1, re2, raddr2, output rdata1, rdata2);
endinterface

// File: rtl/regfile_wb.sv
// regfile_wb: RISC-V integer register file with one writeback write port and two bypassed read ports.
// Ports:
//   clk - pipeline clock, writes on rising edge
//   rst - asynchronous active-high reset, clears all entries and forces reads to 0
//   bus - regfile_wb_if.slave: we/waddr/wdata write, re1/raddr1/rdata1 and re2/raddr2/rdata2 reads
module regfile_wb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic         clk,
    input  logic         rst,
    regfile_wb_if.slave  bus
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_en;

    // x0 is never written, so its entry stays at its reset value of zero.
    assign wr_en = bus.we && (bus.waddr != ADDR_W'(0));

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[bus.waddr] = bus.wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '{default: '0};
        else     regs_q <= regs_d;
    end

    // Same-cycle bypass lets decode see the value being written back this cycle.
    // wdata only reaches the output when we=1, so an undriven wdata cannot leak.
    always_comb begin
        bus.rdata1 = (rst || !bus.re1 || bus.raddr1 == ADDR_W'(0)) ? '0 :
                     (bus.we && bus.waddr == bus.raddr1) ? bus.wdata : regs_q[bus.raddr1];
        bus.rdata2 = (rst || !bus.re2 || bus.raddr2 == ADDR_W'(0)) ? '0 :
                     (bus.we && bus.waddr == bus.raddr2) ? bus.wdata : regs_q[bus.raddr2];
    end
endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed and randomized checks of regfile_wb against a register-array reference model.
module tb_regfile_wb;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] model [32];

    always #5 clk = ~clk;

    regfile_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
        if (rst || !re || ra == 5'd0) return 32'd0;
        if (bus.we && bus.waddr == ra) return bus.wdata;
        return model[ra];
    endfunction

    task automatic set_rst(input logic v);
        rst = v;
        if (v) for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst && bus.we && bus.waddr != 5'd0) model[bus.waddr] = bus.wdata;
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        bus.re1 = e1; bus.raddr1 = a1; bus.re2 = e2; bus.raddr2 = a2;
        #1;
    endtask

    initial begin
        set_rst(1'b1);
        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
        rd(1'b1, 5'd5, 1'b1, 5'd7);
        chk("init_rst_r1", bus.rdata1, 32'd0);
        chk("init_rst_r2", bus.rdata2, 32'd0);
        tick(); tick();
        set_rst(1'b0);

        wr(5'd5, 32'h1234_5678);
        rd(1'b1, 5'd5, 1'b1, 5'd5);
        chk("x5_written", bus.rdata1, 32'h1234_5678);
        #2 set_rst(1'b1);
        #1;
        chk("x5_async_rst_r1", bus.rdata1, 32'd0);
        chk("x5_async_rst_r2", bus.rdata2, 32'd0);
        tick();
        chk("rst_hold_r2", bus.rdata2, 32'd0);
        tick();
        set_rst(1'b0);
        #1;
        chk("x5_after_rst", bus.rdata1, 32'd0);

        wr(5'd7, 32'hDEAD_BEEF);
        rd(1'b1, 5'd7, 1'b0, 5'd0);
        chk("x7_read", bus.rdata1, 32'hDEAD_BEEF);
        rd(1'b0, 5'd7, 1'b0, 5'd0);
        chk("x7_re_off", bus.rdata1, 32'd0);

        bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFF_FFFF;
        rd(1'b1, 5'd0, 1'b1, 5'd0);
        chk("x0_no_bypass", bus.rdata1, 32'd0);
        tick();
        bus.we = 1'b0;
        rd(1'b1, 5'd0, 1'b1, 5'd0);
        chk("x0_r1", bus.rdata1, 32'd0);
        chk("x0_r2", bus.rdata2, 32'd0);

        wr(5'd3, 32'h11);
        bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h22;
        rd(1'b1, 5'd3, 1'b1, 5'd3);
        chk("bypass_r1", bus.rdata1, 32'h22);
        chk("bypass_r2", bus.rdata2, 32'h22);
        tick();
        bus.we = 1'b0;
        #1;
        chk("x3_stored_r1", bus.rdata1, 32'h22);
        chk("x3_stored_r2", bus.rdata2, 32'h22);

        wr(5'd9, 32'hA5A5_A5A5);
        wr(5'd10, 32'h5A5A_5A5A);
        bus.we = 1'b0; bus.waddr = 5'd9; bus.wdata = 'x;
        rd(1'b1, 5'd9, 1'b1, 5'd10);
        chk("x9_nowrite", bus.rdata1, 32'hA5A5_A5A5);
        chk("x10_nowrite", bus.rdata2, 32'h5A5A_5A5A);
        tick();
        bus.wdata = '0;

        bus.we = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h99;
        #2 set_rst(1'b1);
        tick();
        set_rst(1'b0);
        bus.we = 1'b0;
        rd(1'b1, 5'd4, 1'b1, 5'd4);
        chk("x4_rst_drop", bus.rdata1, 32'd0);
        wr(5'd4, 32'h77);
        #1;
        chk("x4_first_write", bus.rdata1, 32'h77);
        chk("x4_first_write_r2", bus.rdata2, 32'h77);

        for (int n = 0; n < 3000; n++) begin
            set_rst($urandom_range(0, 59) == 0);
            bus.we    = $urandom_range(0, 3) != 0;
            bus.waddr = 5'($urandom_range(0, 31));
            bus.wdata = bus.we ? $urandom : 'x;
            bus.re1   = $urandom_range(0, 4) != 0;
            bus.re2   = $urandom_range(0, 4) != 0;
            bus.raddr1 = $urandom_range(0, 3) == 0 ? bus.waddr : 5'($urandom_range(0, 31));
            bus.raddr2 = $urandom_range(0, 3) == 0 ? bus.raddr1 : 5'($urandom_range(0, 31));
            #1;
            chk("rand_r1", bus.rdata1, exp_rd(bus.re1, bus.raddr1));
            chk("rand_r2", bus.rdata2, exp_rd(bus.re2, bus.raddr2));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
